// File: rtl/falu_issue_ctrl_if.sv
// Shared types and the request/ALU/response bundle between a caller and falu_issue_ctrl.
// The slave modport is the controller side; master is the caller/ALU side.
package falu_pkg;
  typedef enum logic [3:0] {
    FADD  = 4'd0,
    FSUB  = 4'd1,
    FMUL  = 4'd2,
    FDIV  = 4'd3,
    FSQRT = 4'd4,
    FMIN  = 4'd5,
    FMAX  = 4'd6,
    FCMP  = 4'd7
  } alu_instruction_t;

  typedef logic [31:0] data_t;
endpackage

interface falu_issue_ctrl_if #(
  parameter int unsigned TAG_W = 4
);
  import falu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  alu_instruction_t req_instr;
  logic [31:0]      req_op1;
  logic [31:0]      req_op2;
  data_t            req_imm;
  logic [TAG_W-1:0] req_tag;

  logic             alu_enable;
  alu_instruction_t alu_instruction;
  logic [31:0]      alu_op1;
  logic [31:0]      alu_op2;
  data_t            alu_imm;
  logic [31:0]      alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  logic             busy;
  logic [31:0]      op_count;

  modport slave (
    input  req_valid, req_instr, req_op1, req_op2, req_imm, req_tag,
    input  alu_result, rsp_ready,
    output req_ready, alu_enable, alu_instruction, alu_op1, alu_op2, alu_imm,
    output rsp_valid, rsp_result, rsp_tag, busy, op_count
  );

  modport master (
    output req_valid, req_instr, req_op1, req_op2, req_imm, req_tag,
    output alu_result, rsp_ready,
    input  req_ready, alu_enable, alu_instruction, alu_op1, alu_op2, alu_imm,
    input  rsp_valid, rsp_result, rsp_tag, busy, op_count
  );
endinterface

// File: rtl/falu_issue_ctrl.sv
// Sequences one floating-ALU operation at a time: latch operands, hold alu_enable for
// ISSUE_CYCLES cycles, capture the registered ALU result and hand it back with its tag.
module falu_issue_ctrl
  import falu_pkg::*;
#(
  parameter int unsigned ISSUE_CYCLES = 4,
  parameter int unsigned TAG_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  falu_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] ISSUE_LAST = 4'(ISSUE_CYCLES - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             alu_enable_q;
  alu_instruction_t alu_instr_q;
  logic [31:0]      alu_op1_q;
  logic [31:0]      alu_op2_q;
  data_t            alu_imm_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [31:0]      op_count_q;

  // All outputs are registered alongside the state so they track it cycle-exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      alu_enable_q <= 1'b0;
      alu_instr_q  <= FADD;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_imm_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            alu_instr_q  <= bus.req_instr;
            alu_op1_q    <= bus.req_op1;
            alu_op2_q    <= bus.req_op2;
            alu_imm_q    <= bus.req_imm;
            rsp_tag_q    <= bus.req_tag;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            alu_enable_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == ISSUE_LAST) begin
            alu_enable_q <= 1'b0;
            state_q      <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_result_q <= bus.alu_result;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          // Returning through IDLE keeps req_ready low during this handshake cycle.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 32'd1;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.busy            = busy_q;
  assign bus.alu_enable      = alu_enable_q;
  assign bus.alu_instruction = alu_instr_q;
  assign bus.alu_op1         = alu_op1_q;
  assign bus.alu_op2         = alu_op2_q;
  assign bus.alu_imm         = alu_imm_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_result      = rsp_result_q;
  assign bus.rsp_tag         = rsp_tag_q;
  assign bus.op_count        = op_count_q;

endmodule

// File: tb/tb_falu_issue_ctrl.sv
// Directed bench for falu_issue_ctrl: an ISSUE_CYCLES=4 instance for the main sequences
// and an ISSUE_CYCLES=1 instance for the shortest issue window.
module tb_falu_issue_ctrl;
  import falu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cnum;

  falu_issue_ctrl_if #(.TAG_W(4)) b4 ();
  falu_issue_ctrl_if #(.TAG_W(4)) b1 ();

  falu_issue_ctrl #(.ISSUE_CYCLES(4), .TAG_W(4)) dut4 (.clk(clk), .reset(rst), .bus(b4.slave));
  falu_issue_ctrl #(.ISSUE_CYCLES(1), .TAG_W(4)) dut1 (.clk(clk), .reset(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; alu_result carries the cycle number so captures are traceable.
  task automatic tick();
    @(negedge clk);
    cnum++;
    b4.alu_result = {16'hC0DE, 16'(cnum)};
  endtask

  int acc_cyc [3];
  int rsp_tags[3];
  int acc_n;
  int rsp_n;
  int pulses;
  bit seen;

  initial begin
    checks = 0; failures = 0; cnum = 0;
    rst = 1'b1;
    b4.req_valid = 0; b4.req_instr = FADD; b4.req_op1 = '0; b4.req_op2 = '0;
    b4.req_imm = '0; b4.req_tag = '0; b4.alu_result = '0; b4.rsp_ready = 0;
    b1.req_valid = 0; b1.req_instr = FADD; b1.req_op1 = '0; b1.req_op2 = '0;
    b1.req_imm = '0; b1.req_tag = '0; b1.alu_result = '0; b1.rsp_ready = 0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 64'(b4.req_ready), 64'd1);
    chk("rst_busy", 64'(b4.busy), 64'd0);
    chk("rst_alu_enable", 64'(b4.alu_enable), 64'd0);
    chk("rst_rsp_valid", 64'(b4.rsp_valid), 64'd0);
    chk("rst_op_count", 64'(b4.op_count), 64'd0);
    chk("rst_alu_op1", 64'(b4.alu_op1), 64'd0);
    chk("rst_rsp_tag", 64'(b4.rsp_tag), 64'd0);
    chk("rst_instr", 64'(b4.alu_instruction), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single FADD, rsp_ready held high
    cnum = 0; b4.alu_result = 32'hC0DE0000;
    b4.req_valid = 1; b4.req_instr = FADD; b4.req_op1 = 32'h3F800000;
    b4.req_op2 = 32'h40000000; b4.req_imm = 32'h11; b4.req_tag = 4'd3; b4.rsp_ready = 1;
    chk("t1_c0_req_ready", 64'(b4.req_ready), 64'd1);
    tick(); b4.req_valid = 0;
    chk("t1_c1_en", 64'(b4.alu_enable), 64'd1);
    chk("t1_c1_busy", 64'(b4.busy), 64'd1);
    chk("t1_c1_req_ready", 64'(b4.req_ready), 64'd0);
    chk("t1_c1_op1", 64'(b4.alu_op1), 64'h3F800000);
    chk("t1_c1_op2", 64'(b4.alu_op2), 64'h40000000);
    chk("t1_c1_imm", 64'(b4.alu_imm), 64'h11);
    chk("t1_c1_instr", 64'(b4.alu_instruction), 64'(FADD));
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("t1_issue_en", 64'(b4.alu_enable), 64'd1);
    end
    tick();
    chk("t1_c5_en", 64'(b4.alu_enable), 64'd0);
    chk("t1_c5_rsp_valid", 64'(b4.rsp_valid), 64'd0);
    tick();
    chk("t1_c6_rsp_valid", 64'(b4.rsp_valid), 64'd1);
    chk("t1_c6_result", 64'(b4.rsp_result), 64'hC0DE0005);
    chk("t1_c6_tag", 64'(b4.rsp_tag), 64'd3);
    tick();
    chk("t1_c7_rsp_valid", 64'(b4.rsp_valid), 64'd0);
    chk("t1_c7_op_count", 64'(b4.op_count), 64'd1);
    chk("t1_c7_busy", 64'(b4.busy), 64'd0);
    chk("t1_c7_req_ready", 64'(b4.req_ready), 64'd1);

    // Backpressure with a second request held pending
    cnum = 0; b4.alu_result = 32'hC0DE0000;
    b4.req_valid = 1; b4.req_instr = FMUL; b4.req_op1 = 32'h40400000;
    b4.req_op2 = 32'h40800000; b4.req_imm = 32'h55; b4.req_tag = 4'd5; b4.rsp_ready = 0;
    tick();
    b4.req_instr = FSUB; b4.req_op1 = 32'hDEADBEEF; b4.req_tag = 4'd9;
    for (int i = 2; i <= 6; i++) tick();
    chk("t2_c6_rsp_valid", 64'(b4.rsp_valid), 64'd1);
    chk("t2_c6_result", 64'(b4.rsp_result), 64'hC0DE0005);
    for (int k = 0; k < 10; k++) begin
      chk("t2_hold_valid", 64'(b4.rsp_valid), 64'd1);
      chk("t2_hold_result", 64'(b4.rsp_result), 64'hC0DE0005);
      chk("t2_hold_tag", 64'(b4.rsp_tag), 64'd5);
      chk("t2_hold_req_ready", 64'(b4.req_ready), 64'd0);
      chk("t2_hold_op1", 64'(b4.alu_op1), 64'h40400000);
      tick();
    end
    b4.rsp_ready = 1;
    chk("t2_c16_valid", 64'(b4.rsp_valid), 64'd1);
    tick();
    chk("t2_c17_rsp_valid", 64'(b4.rsp_valid), 64'd0);
    chk("t2_c17_req_ready", 64'(b4.req_ready), 64'd1);
    chk("t2_c17_op_count", 64'(b4.op_count), 64'd2);
    tick(); b4.req_valid = 0;
    chk("t2_c18_en", 64'(b4.alu_enable), 64'd1);
    chk("t2_c18_op1", 64'(b4.alu_op1), 64'hDEADBEEF);
    chk("t2_c18_tag", 64'(b4.rsp_tag), 64'd9);
    chk("t2_c18_instr", 64'(b4.alu_instruction), 64'(FSUB));
    for (int i = 19; i <= 23; i++) tick();
    chk("t2_c23_valid", 64'(b4.rsp_valid), 64'd1);
    chk("t2_c23_result", 64'(b4.rsp_result), 64'hC0DE0016);
    chk("t2_c23_tag", 64'(b4.rsp_tag), 64'd9);
    tick();
    chk("t2_c24_op_count", 64'(b4.op_count), 64'd3);

    // Back-to-back requests with req_valid held high
    acc_n = 0; rsp_n = 0;
    b4.req_valid = 1; b4.req_tag = 4'd1; b4.rsp_ready = 1;
    for (int i = 0; i < 40 && rsp_n < 3; i++) begin
      seen = 0;
      if (b4.req_valid && b4.req_ready) begin
        acc_cyc[acc_n] = i; acc_n++; seen = 1;
      end
      if (b4.rsp_valid && b4.rsp_ready) begin
        rsp_tags[rsp_n] = int'(b4.rsp_tag); rsp_n++;
      end
      tick();
      if (seen) begin
        if (acc_n == 3) b4.req_valid = 0;
        else b4.req_tag = 4'(acc_n + 1);
      end
    end
    chk("t3_acc_count", 64'(acc_n), 64'd3);
    chk("t3_rsp_count", 64'(rsp_n), 64'd3);
    if (acc_n == 3) begin
      chk("t3_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd7);
      chk("t3_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd7);
    end
    if (rsp_n == 3) begin
      chk("t3_tag0", 64'(rsp_tags[0]), 64'd1);
      chk("t3_tag1", 64'(rsp_tags[1]), 64'd2);
      chk("t3_tag2", 64'(rsp_tags[2]), 64'd3);
    end
    chk("t3_op_count", 64'(b4.op_count), 64'd6);

    // Reset in the second ISSUE cycle
    b4.req_valid = 1; b4.req_tag = 4'd2; b4.rsp_ready = 1;
    tick(); b4.req_valid = 0;
    tick();
    chk("t4_c2_en", 64'(b4.alu_enable), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t4_async_en", 64'(b4.alu_enable), 64'd0);
    chk("t4_busy", 64'(b4.busy), 64'd0);
    chk("t4_req_ready", 64'(b4.req_ready), 64'd1);
    chk("t4_op_count", 64'(b4.op_count), 64'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b4.rsp_valid || b4.busy) pulses++;
    end
    chk("t4_no_resp", 64'(pulses), 64'd0);
    chk("t4_op_count_after", 64'(b4.op_count), 64'd0);

    // op_count wrap
    force dut4.op_count_q = 32'hFFFFFFFF;
    tick();
    release dut4.op_count_q;
    chk("t5_preload", 64'(b4.op_count), 64'hFFFFFFFF);
    b4.req_valid = 1; b4.req_tag = 4'd4;
    tick(); b4.req_valid = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (b4.rsp_valid) begin
        seen = 1;
        chk("t5_tag", 64'(b4.rsp_tag), 64'd4);
      end
      tick();
    end
    chk("t5_seen_rsp", 64'(seen), 64'd1);
    chk("t5_wrap", 64'(b4.op_count), 64'd0);

    // ISSUE_CYCLES=1 instance
    b1.req_valid = 1; b1.req_instr = FDIV; b1.req_op1 = 32'h41200000;
    b1.req_op2 = 32'h40A00000; b1.req_tag = 4'd7; b1.rsp_ready = 1;
    @(negedge clk); b1.req_valid = 0;
    chk("t6_c1_en", 64'(b1.alu_enable), 64'd1);
    chk("t6_c1_op1", 64'(b1.alu_op1), 64'h41200000);
    @(negedge clk); b1.alu_result = 32'h12345678;
    chk("t6_c2_en", 64'(b1.alu_enable), 64'd0);
    chk("t6_c2_valid", 64'(b1.rsp_valid), 64'd0);
    @(negedge clk); b1.alu_result = 32'hFFFF0000;
    chk("t6_c3_valid", 64'(b1.rsp_valid), 64'd1);
    chk("t6_c3_result", 64'(b1.rsp_result), 64'h12345678);
    chk("t6_c3_tag", 64'(b1.rsp_tag), 64'd7);
    @(negedge clk);
    chk("t6_c4_valid", 64'(b1.rsp_valid), 64'd0);
    chk("t6_c4_op_count", 64'(b1.op_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/falu_issue_ctrl.md
FALU_ISSUE_CTRL -- requirements
Module: falu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter ISSUE_CYCLES, default 4, SHALL set the number of consecutive cycles alu_enable is held high per operation (legal range 1..15).
REQ-003 Parameter TAG_W, default 4, SHALL set the request/response tag width.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_instr  in  alu_instruction_t  FP operation
- req_op1, req_op2  in  32  operands
- req_imm  in  data_t  immediate
- req_tag  in  TAG_W  caller tag
- alu_enable  out  1  drives floating ALU enable
- alu_instruction  out  alu_instruction_t  latched operation
- alu_op1, alu_op2  out  32  latched operands
- alu_imm  out  data_t  latched immediate
- alu_result  in  32  floating ALU registered result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  captured result
- rsp_tag  out  TAG_W  tag of the completed request
- busy  out  1  high whenever state is not IDLE
- op_count  out  32  count of completed responses

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and RESP; exactly one operation SHALL be in flight at a time.
REQ-006 req_ready SHALL be high only in IDLE.
REQ-007 In IDLE, on req_valid && req_ready, the block SHALL latch instr/op1/op2/imm/tag into the alu_* and rsp_tag registers, clear the issue counter, and go to ISSUE.
REQ-008 alu_* operand outputs SHALL remain stable from acceptance until the next acceptance.
REQ-009 In ISSUE, alu_enable SHALL be high; the counter SHALL increment each cycle.
- After ISSUE_CYCLES cycles in ISSUE, the FSM SHALL go to CAPTURE.
- alu_enable SHALL be high for exactly ISSUE_CYCLES consecutive cycles per operation.
REQ-010 In CAPTURE, alu_enable SHALL be low; at the end of that cycle, rsp_result SHALL load alu_result, rsp_valid SHALL set, and the FSM SHALL go to RESP.
REQ-011 Timing: with the request handshake in cycle 0, alu_enable SHALL be high in cycles 1..ISSUE_CYCLES, CAPTURE SHALL be cycle ISSUE_CYCLES+1, and rsp_valid SHALL first be high in cycle ISSUE_CYCLES+2.
REQ-012 In RESP, rsp_valid, rsp_result and rsp_tag SHALL hold stable until rsp_ready is sampled high.
- On that handshake, rsp_valid SHALL clear, op_count SHALL increment by 1, and the FSM SHALL return to IDLE.
REQ-013 A new request offered during the RESP handshake cycle SHALL NOT be accepted (req_ready low); it SHALL be accepted in the following IDLE cycle, giving a minimum spacing of ISSUE_CYCLES+3 cycles between acceptances.
REQ-014 op_count SHALL wrap from 32'hFFFFFFFF to 0 with no other side effect.
REQ-015 rsp_ready asserted outside RESP SHALL have no effect; req_valid outside IDLE SHALL have no effect.
REQ-016 The block SHALL NOT inspect or modify result values; rsp_result SHALL be bit-identical to alu_result sampled in CAPTURE.

Reset
REQ-017 While reset is high, asynchronously:
- state SHALL be IDLE;
- alu_enable, rsp_valid and busy SHALL be 0;
- req_ready SHALL be 1;
- alu_op1, alu_op2, alu_imm, rsp_result, rsp_tag and op_count SHALL be 0;
- alu_instruction SHALL be its enumeration value 0.
REQ-018 Reset asserted mid-operation (ISSUE, CAPTURE or RESP) SHALL abort the operation with no response produced and no op_count change; alu_enable SHALL drop without waiting for a clock edge.

Verification
REQ-019 FADD, op1=32'h3F800000, op2=32'h40000000, tag=3, rsp_ready=1, ISSUE_CYCLES=4 -> alu_enable high in cycles 1-4; rsp_valid in cycle 6 with rsp_result = alu_result from cycle 5, rsp_tag=3; op_count=1.
REQ-020 Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid/result/tag stable, req_ready=0, second req_valid ignored; after rsp_ready=1, IDLE, then second request accepted in the next cycle.
REQ-021 Back-to-back: req_valid held high for 3 requests, rsp_ready=1 -> acceptances exactly ISSUE_CYCLES+3 cycles apart; tags returned in order; op_count=3.
REQ-022 Reset asserted in cycle 2 of ISSUE -> alu_enable falls asynchronously; after reset, busy=0, req_ready=1, op_count=0, no rsp_valid pulse.
REQ-023 op_count preloaded by forcing to 32'hFFFFFFFF, one completed op -> op_count=0.
REQ-024 ISSUE_CYCLES=1 build -> alu_enable high for exactly one cycle; rsp_valid in cycle 3 after handshake.
